// File: rtl/operand_issue_ctrl.sv
// ID->EX issue controller: registers operands and controls into EX, forwards
// EX/MEM and MEM/WB results, and inserts load-use / flush bubbles.
module operand_issue_ctrl #(
    parameter int DATA_WID = 16,
    parameter int REG_WID  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [2:0]          id_alu_src,
    input  logic [REG_WID-1:0]  id_ra,
    input  logic [REG_WID-1:0]  id_rb,
    input  logic                id_store,
    input  logic [REG_WID-1:0]  id_rd,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic [DATA_WID-1:0] read_data_A,
    input  logic [DATA_WID-1:0] read_data_B,
    input  logic                flush,
    input  logic                mem_busy,
    input  logic [REG_WID-1:0]  exmem_rd,
    input  logic                exmem_reg_write,
    input  logic [DATA_WID-1:0] exmem_data,
    input  logic [REG_WID-1:0]  memwb_rd,
    input  logic                memwb_reg_write,
    input  logic [DATA_WID-1:0] memwb_data,
    output logic                ex_valid,
    output logic [2:0]          ex_alu_src,
    output logic [DATA_WID-1:0] fwd_data_A,
    output logic [DATA_WID-1:0] fwd_data_B,
    output logic [REG_WID-1:0]  ex_rd,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                stall_id,
    output logic [15:0]         stall_cnt
);

    localparam logic [2:0] SRC_NULL  = 3'b000;
    localparam logic [2:0] SRC_R1_R2 = 3'b001;
    localparam logic [2:0] SRC_R1_IM = 3'b010;
    localparam logic [2:0] SRC_R1_NU = 3'b011;
    localparam logic [2:0] SRC_IM_NU = 3'b100;
    localparam logic [2:0] SRC_R2_R1 = 3'b101;

    logic                ex_valid_q, ex_valid_d;
    logic [2:0]          ex_alu_src_q, ex_alu_src_d;
    logic [REG_WID-1:0]  ex_ra_q, ex_ra_d;
    logic [REG_WID-1:0]  ex_rb_q, ex_rb_d;
    logic [REG_WID-1:0]  ex_rd_q, ex_rd_d;
    logic                ex_reg_write_q, ex_reg_write_d;
    logic                ex_mem_read_q, ex_mem_read_d;
    logic [DATA_WID-1:0] ex_data_a_q, ex_data_a_d;
    logic [DATA_WID-1:0] ex_data_b_q, ex_data_b_d;
    logic [15:0]         stall_cnt_q, stall_cnt_d;

    logic                uses_a, uses_b, lu;
    logic [2:0]          id_src_norm;
    logic [DATA_WID-1:0] id_data_a, id_data_b;

    // Decode operand use; 110/111 behave as null and register as 000.
    always_comb begin
        uses_a      = 1'b0;
        uses_b      = id_store;
        id_src_norm = SRC_NULL;
        case (id_alu_src)
            SRC_R1_R2: begin uses_a = 1'b1; uses_b = 1'b1; id_src_norm = SRC_R1_R2; end
            SRC_R1_IM: begin uses_a = 1'b1; id_src_norm = SRC_R1_IM; end
            SRC_R1_NU: begin uses_a = 1'b1; id_src_norm = SRC_R1_NU; end
            SRC_IM_NU: id_src_norm = SRC_IM_NU;
            SRC_R2_R1: begin uses_a = 1'b1; uses_b = 1'b1; id_src_norm = SRC_R2_R1; end
            default:   id_src_norm = SRC_NULL;
        endcase
    end

    always_comb begin
        lu = id_valid & ex_valid_q & ex_mem_read_q & ex_reg_write_q &
             ((uses_a & (id_ra == ex_rd_q)) | (uses_b & (id_rb == ex_rd_q)));
        stall_id = mem_busy | lu;
    end

    // Writeback in the same cycle as ID read: take the value being written.
    always_comb begin
        id_data_a = (memwb_reg_write && memwb_rd == id_ra) ? memwb_data : read_data_A;
        id_data_b = (memwb_reg_write && memwb_rd == id_rb) ? memwb_data : read_data_B;
    end

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_alu_src_d   = ex_alu_src_q;
        ex_ra_d        = ex_ra_q;
        ex_rb_d        = ex_rb_q;
        ex_rd_d        = ex_rd_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_data_a_d    = ex_data_a_q;
        ex_data_b_d    = ex_data_b_q;
        stall_cnt_d    = stall_cnt_q;
        if (!mem_busy) begin
            if (flush || lu) begin
                ex_valid_d     = 1'b0;
                ex_alu_src_d   = SRC_NULL;
                ex_reg_write_d = 1'b0;
                ex_mem_read_d  = 1'b0;
                // A flush bubble is not a load-use stall, even when both coincide.
                if (!flush && stall_cnt_q != 16'hFFFF) begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
            end else begin
                ex_valid_d     = id_valid;
                ex_alu_src_d   = id_valid ? id_src_norm : SRC_NULL;
                ex_ra_d        = id_ra;
                ex_rb_d        = id_rb;
                ex_rd_d        = id_rd;
                ex_reg_write_d = id_valid & id_reg_write;
                ex_mem_read_d  = id_valid & id_mem_read;
                ex_data_a_d    = id_data_a;
                ex_data_b_d    = id_data_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q     <= 1'b0;
            ex_alu_src_q   <= SRC_NULL;
            ex_ra_q        <= '0;
            ex_rb_q        <= '0;
            ex_rd_q        <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_data_a_q    <= '0;
            ex_data_b_q    <= '0;
            stall_cnt_q    <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_alu_src_q   <= ex_alu_src_d;
            ex_ra_q        <= ex_ra_d;
            ex_rb_q        <= ex_rb_d;
            ex_rd_q        <= ex_rd_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_data_a_q    <= ex_data_a_d;
            ex_data_b_q    <= ex_data_b_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    // EX/MEM is younger than MEM/WB, so it wins; bubbles are forwarded too.
    always_comb begin
        if (exmem_reg_write && exmem_rd == ex_ra_q)      fwd_data_A = exmem_data;
        else if (memwb_reg_write && memwb_rd == ex_ra_q) fwd_data_A = memwb_data;
        else                                             fwd_data_A = ex_data_a_q;
        if (exmem_reg_write && exmem_rd == ex_rb_q)      fwd_data_B = exmem_data;
        else if (memwb_reg_write && memwb_rd == ex_rb_q) fwd_data_B = memwb_data;
        else                                             fwd_data_B = ex_data_b_q;
    end

    assign ex_valid     = ex_valid_q;
    assign ex_alu_src   = ex_alu_src_q;
    assign ex_rd        = ex_rd_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_operand_issue_ctrl.sv
// Directed vector table for operand_issue_ctrl plus a reset-during-stall sequence.
module tb_operand_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_alu_src;
    logic [3:0]  id_ra, id_rb, id_rd;
    logic        id_store, id_reg_write, id_mem_read;
    logic [15:0] read_data_A, read_data_B;
    logic        flush, mem_busy;
    logic [3:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [15:0] exmem_data, memwb_data;
    logic        ex_valid;
    logic [2:0]  ex_alu_src;
    logic [15:0] fwd_data_A, fwd_data_B;
    logic [3:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, stall_id;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    operand_issue_ctrl #(.DATA_WID(16), .REG_WID(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_alu_src(id_alu_src), .id_ra(id_ra), .id_rb(id_rb),
        .id_store(id_store), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .read_data_A(read_data_A), .read_data_B(read_data_B),
        .flush(flush), .mem_busy(mem_busy),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_data(exmem_data),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_data(memwb_data),
        .ex_valid(ex_valid), .ex_alu_src(ex_alu_src),
        .fwd_data_A(fwd_data_A), .fwd_data_B(fwd_data_B),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .stall_id(stall_id), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: inputs (v src ra rb rd rw mr st rda rdb mwrd mwwe mwd emrd emwe emd fl busy),
    // then expected (stall_id before edge; valid src chk_fwd fa fb cnt after edge).
    typedef struct {
        logic v; logic [2:0] src; logic [3:0] ra, rb, rd; logic rw, mr, st;
        logic [15:0] rda, rdb;
        logic [3:0] mwrd; logic mwwe; logic [15:0] mwd;
        logic [3:0] emrd; logic emwe; logic [15:0] emd;
        logic fl, busy;
        logic e_stall, e_valid; logic [2:0] e_src; logic chk_fwd;
        logic [15:0] e_fa, e_fb, e_cnt;
    } vec_t;

    vec_t tbl[23];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid = t.v; id_alu_src = t.src; id_ra = t.ra; id_rb = t.rb; id_rd = t.rd;
        id_reg_write = t.rw; id_mem_read = t.mr; id_store = t.st;
        read_data_A = t.rda; read_data_B = t.rdb;
        memwb_rd = t.mwrd; memwb_reg_write = t.mwwe; memwb_data = t.mwd;
        exmem_rd = t.emrd; exmem_reg_write = t.emwe; exmem_data = t.emd;
        flush = t.fl; mem_busy = t.busy;
    endtask

    initial begin
        tbl[0]  = '{1,3'b010,1,0,0,0,0,0,16'h1234,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0,0,
                    0,1,3'b010,1,16'h1234,16'h0000,16'd0};
        tbl[1]  = '{1,3'b001,1,2,3,1,0,0,16'h0011,16'h0022, 0,0,16'h0000, 0,0,16'h0000, 0,0,
                    0,1,3'b001,1,16'h0011,16'h0022,16'd0};
        tbl[2]  = '{0,3'b000,0,0,0,0,0,0,16'h0000,16'h0000, 1,1,16'h00BB, 1,1,16'h00AA, 1,1,
                    1,1,3'b001,1,16'h00AA,16'h0022,16'd0};
        tbl[3]  = '{0,3'b000,0,0,0,0,0,0,16'h0000,16'h0000, 1,1,16'h00BB, 1,0,16'h00AA, 0,1,
                    1,1,3'b001,1,16'h00BB,16'h0022,16'd0};
        tbl[4]  = '{0,3'b000,0,0,0,0,0,0,16'h0000,16'h0000, 2,1,16'h0DDD, 2,1,16'h0CCC, 0,1,
                    1,1,3'b001,1,16'h0011,16'h0CCC,16'd0};
        tbl[5]  = '{1,3'b010,1,0,2,1,1,0,16'h0100,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0,0,
                    0,1,3'b010,1,16'h0100,16'h0000,16'd0};
        tbl[6]  = '{1,3'b001,2,1,4,1,0,0,16'h0000,16'h0100, 0,0,16'h0000, 0,0,16'h0000, 0,0,
                    1,0,3'b000,0,16'h0000,16'h0000,16'd1};
        tbl[7]  = '{1,3'b001,2,1,4,1,0,0,16'h0000,16'h0100, 2,1,16'hBEEF, 0,0,16'h0000, 0,0,
                    0,1,3'b001,1,16'hBEEF,16'h0100,16'd1};
        tbl[8]  = '{1,3'b010,1,0,2,1,1,0,16'h0007,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0,0,
                    0,1,3'b010,1,16'h0007,16'h0000,16'd1};
        tbl[9]  = '{1,3'b100,2,0,5,1,0,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0,0,
                    0,1,3'b100,1,16'h0000,16'h0000,16'd1};
        tbl[10] = '{1,3'b010,1,0,3,1,1,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0,0,
                    0,1,3'b010,0,16'h0000,16'h0000,16'd1};
        tbl[11] = '{1,3'b010,0,3,0,0,0,1,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0,0,
                    1,0,3'b000,0,16'h0000,16'h0000,16'd2};
        tbl[12] = '{1,3'b010,1,0,3,1,1,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0,0,
                    0,1,3'b010,0,16'h0000,16'h0000,16'd2};
        tbl[13] = '{1,3'b001,3,0,4,1,0,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 1,0,
                    1,0,3'b000,0,16'h0000,16'h0000,16'd2};
        tbl[14] = '{1,3'b111,3,3,0,0,0,0,16'h1111,16'h2222, 0,0,16'h0000, 0,0,16'h0000, 0,0,
                    0,1,3'b000,1,16'h1111,16'h2222,16'd2};
        tbl[15] = '{0,3'b001,1,2,3,1,0,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0,0,
                    0,0,3'b000,0,16'h0000,16'h0000,16'd2};
        tbl[16] = '{1,3'b001,1,2,3,1,0,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 1,0,
                    0,0,3'b000,0,16'h0000,16'h0000,16'd2};
        tbl[17] = '{1,3'b101,4,5,6,1,0,0,16'h0044,16'h0055, 0,0,16'h0000, 0,0,16'h0000, 0,0,
                    0,1,3'b101,1,16'h0044,16'h0055,16'd2};
        tbl[18] = '{1,3'b010,0,0,0,0,0,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0,1,
                    1,1,3'b101,1,16'h0044,16'h0055,16'd2};
        tbl[19] = '{1,3'b010,0,0,0,0,0,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 1,1,
                    1,1,3'b101,1,16'h0044,16'h0055,16'd2};
        tbl[20] = '{1,3'b010,0,0,0,0,0,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0,1,
                    1,1,3'b101,1,16'h0044,16'h0055,16'd2};
        tbl[21] = '{1,3'b011,5,0,0,0,0,0,16'h0000,16'h0000, 5,1,16'h5A5A, 0,0,16'h0000, 0,0,
                    0,1,3'b011,1,16'h5A5A,16'h0000,16'd2};
        tbl[22] = '{0,3'b000,0,0,0,0,0,0,16'h0000,16'h0000, 0,0,16'h0000, 0,0,16'h0000, 0,1,
                    1,1,3'b011,1,16'h5A5A,16'h0000,16'd2};

        // Clock/reset
        rst = 1'b0;
        drive(tbl[15]);
        id_valid = 1'b0; flush = 1'b0; mem_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ex_valid", {15'd0, ex_valid}, 16'd0);
        check("rst_ex_alu_src", {13'd0, ex_alu_src}, 16'd0);
        check("rst_stall_cnt", stall_cnt, 16'd0);
        check("rst_stall_id", {15'd0, stall_id}, 16'd0);
        check("rst_fwd_a", fwd_data_A, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check($sformatf("v%0d_stall_id", i), {15'd0, stall_id}, {15'd0, tbl[i].e_stall});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ex_valid", i), {15'd0, ex_valid}, {15'd0, tbl[i].e_valid});
            check($sformatf("v%0d_ex_alu_src", i), {13'd0, ex_alu_src}, {13'd0, tbl[i].e_src});
            check($sformatf("v%0d_stall_cnt", i), stall_cnt, tbl[i].e_cnt);
            if (tbl[i].chk_fwd) begin
                check($sformatf("v%0d_fwd_a", i), fwd_data_A, tbl[i].e_fa);
                check($sformatf("v%0d_fwd_b", i), fwd_data_B, tbl[i].e_fb);
            end
        end

        // Reset asserted while a load-use stall is pending.
        @(negedge clk);
        drive(tbl[12]);
        @(posedge clk);
        #1;
        check("mid_load_in_ex", {15'd0, ex_mem_read}, 16'd1);
        @(negedge clk);
        drive(tbl[13]);
        flush = 1'b0;
        #1;
        check("mid_stall_before_rst", {15'd0, stall_id}, 16'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_ex_valid", {15'd0, ex_valid}, 16'd0);
        check("mid_rst_stall_cnt", stall_cnt, 16'd0);
        check("mid_rst_stall_id", {15'd0, stall_id}, 16'd0);
        check("mid_rst_ex_alu_src", {13'd0, ex_alu_src}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ex_valid", {15'd0, ex_valid}, 16'd1);
        check("post_rst_ex_alu_src", {13'd0, ex_alu_src}, 16'd1);
        check("post_rst_stall_cnt", stall_cnt, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
